// File: rtl/memory_double_stage.sv
// memory_double_stage: dual-issue memory stage serialising two lanes over one dcache port
package memory_double_stage_pkg;
  typedef enum logic [4:0] {
    OP_NOP, OP_ADD, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
    OP_SB, OP_SH, OP_SW, OP_ERET, OP_MTC0
  } op_t;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  typedef struct packed {
    logic        valid;
    logic [4:0]  id;
    logic [31:0] value;
  } reg_write_t;
  typedef struct packed {
    logic        valid;
    logic [4:0]  exccode;
    logic [31:0] badvaddr;
  } exception_t;
  typedef struct packed {
    op_t         op;
    logic [31:0] pc;
    reg_write_t  write_reg;
    logic [31:0] store_data;
    exception_t  exception;
  } write_single_context_t;
  localparam write_single_context_t CTX_NOP = '0;
endpackage

module memory_double_stage
  import memory_double_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  write_single_context_t execute2memory_1,
  input  write_single_context_t execute2memory_2,
  input  logic                  flush,
  output logic                  dreq_valid,
  output logic [31:0]           dreq_addr,
  output logic [1:0]            dreq_size,
  output logic [3:0]            dreq_strobe,
  output logic [31:0]           dreq_data,
  input  logic                  dresp_addr_ok,
  input  logic                  dresp_data_ok,
  input  logic [31:0]           dresp_rdata,
  output write_single_context_t memory2write_1,
  output write_single_context_t memory2write_2
);
  typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, DRAIN} state_t;

  function automatic logic is_load(op_t op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
  endfunction

  function automatic logic is_store(op_t op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic [1:0] size_of(op_t op);
    return (op inside {OP_LW, OP_SW}) ? 2'd2 : (op inside {OP_LH, OP_LHU, OP_SH}) ? 2'd1 : 2'd0;
  endfunction

  // An exception already raised upstream takes precedence over alignment faults
  function automatic write_single_context_t align(write_single_context_t c);
    write_single_context_t r;
    logic [31:0] a;
    logic mis;
    r = c;
    a = c.write_reg.value;
    mis = (size_of(c.op) == 2'd2 && a[1:0] != 2'b00) || (size_of(c.op) == 2'd1 && a[0]);
    if (mis && !c.exception.valid) begin
      r.exception.valid = 1'b1;
      r.exception.exccode = is_store(c.op) ? EXC_ADES : EXC_ADEL;
      r.exception.badvaddr = a;
    end
    return r;
  endfunction

  function automatic logic [31:0] load_value(op_t op, logic [1:0] b, logic [31:0] d);
    logic [7:0] by;
    logic [15:0] hw;
    by = 8'(d >> {b, 3'b000});
    hw = b[1] ? d[31:16] : d[15:0];
    return (op == OP_LB) ? {{24{by[7]}}, by} :
           (op == OP_LBU) ? {24'b0, by} :
           (op == OP_LH) ? {{16{hw[15]}}, hw} :
           (op == OP_LHU) ? {16'b0, hw} : d;
  endfunction

  state_t r_state;
  write_single_context_t r_l1, r_l2;
  logic r_l2_live;

  write_single_context_t w_a1, w_a2, w_cur, w_fill;
  logic w_kill, w_go1, w_go2, w_req, w_lane1, w_accepted, w_done;

  assign w_a1  = align(execute2memory_1);
  assign w_kill = w_a1.exception.valid || execute2memory_1.op inside {OP_ERET, OP_MTC0};
  assign w_a2  = w_kill ? execute2memory_2 : align(execute2memory_2);
  assign w_go1 = (is_load(w_a1.op) || is_store(w_a1.op)) && !w_a1.exception.valid;
  assign w_go2 = !w_kill && (is_load(w_a2.op) || is_store(w_a2.op)) && !w_a2.exception.valid;

  assign w_req      = (r_state == REQ1) || (r_state == REQ2);
  assign w_lane1    = (r_state == REQ1) || (r_state == WAIT1);
  assign w_accepted = !w_req || dresp_addr_ok;
  assign w_done     = w_accepted && dresp_data_ok;
  assign w_cur      = w_lane1 ? r_l1 : r_l2;

  always_comb begin
    w_fill = w_cur;
    if (is_load(w_cur.op))
      w_fill.write_reg.value = load_value(w_cur.op, w_cur.write_reg.value[1:0], dresp_rdata);
  end

  assign in_ready    = (r_state == IDLE);
  assign dreq_valid  = w_req;
  assign dreq_addr   = w_cur.write_reg.value;
  assign dreq_size   = size_of(w_cur.op);
  assign dreq_strobe = (w_cur.op == OP_SW) ? 4'hf :
                       (w_cur.op == OP_SH) ? (w_cur.write_reg.value[1] ? 4'hc : 4'h3) :
                       (w_cur.op == OP_SB) ? 4'(4'b0001 << w_cur.write_reg.value[1:0]) : 4'h0;
  assign dreq_data   = (w_cur.op == OP_SB) ? {4{w_cur.store_data[7:0]}} :
                       (w_cur.op == OP_SH) ? {2{w_cur.store_data[15:0]}} : w_cur.store_data;

  // A flushed request the cache already accepted still owes a response, so it drains
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_l1 <= CTX_NOP;
      r_l2 <= CTX_NOP;
      r_l2_live <= 1'b0;
      memory2write_1 <= CTX_NOP;
      memory2write_2 <= CTX_NOP;
    end else begin
      memory2write_1 <= CTX_NOP;
      memory2write_2 <= CTX_NOP;
      case (r_state)
        IDLE: if (!flush && in_valid) begin
          r_l1 <= w_a1;
          r_l2 <= w_a2;
          r_l2_live <= w_go2;
          if (w_go1) r_state <= REQ1;
          else if (w_go2) r_state <= REQ2;
          else begin
            memory2write_1 <= w_a1;
            memory2write_2 <= w_a2;
          end
        end
        REQ1, WAIT1, REQ2, WAIT2:
          if (flush) r_state <= (w_accepted && !dresp_data_ok) ? DRAIN : IDLE;
          else if (w_done && w_lane1 && r_l2_live) begin
            r_l1 <= w_fill;
            r_state <= REQ2;
          end else if (w_done) begin
            r_state <= IDLE;
            memory2write_1 <= w_lane1 ? w_fill : r_l1;
            memory2write_2 <= w_lane1 ? r_l2 : w_fill;
          end else if (w_req && dresp_addr_ok) r_state <= w_lane1 ? WAIT1 : WAIT2;
        DRAIN: if (dresp_data_ok) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_double_stage.sv
// tb_memory_double_stage: directed and random bundles against a byte-level reference model
module tb_memory_double_stage;
  import memory_double_stage_pkg::*;

  logic clk = 0, resetn = 0, in_valid = 0, flush = 0, addr_ok = 0, data_ok = 0;
  logic [31:0] rdata = 0;
  logic in_ready, dreq_valid;
  logic [31:0] dreq_addr, dreq_data;
  logic [1:0] dreq_size;
  logic [3:0] dreq_strobe;
  write_single_context_t c1 = '0, c2 = '0, m1, m2, o1, o2, t1, t2;
  int n_cmp = 0, n_err = 0;

  memory_double_stage dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .execute2memory_1(c1), .execute2memory_2(c2), .flush(flush),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(addr_ok), .dresp_data_ok(data_ok), .dresp_rdata(rdata),
    .memory2write_1(m1), .memory2write_2(m2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_st(op_t op);
    return op == OP_SB || op == OP_SH || op == OP_SW;
  endfunction

  function automatic write_single_context_t ref_check(write_single_context_t c);
    write_single_context_t r = c;
    int n = nbytes(c.op);
    if (n > 0 && !c.exception.valid && (c.write_reg.value % n) != 0) begin
      r.exception.valid = 1;
      r.exception.exccode = is_st(c.op) ? 5'd5 : 5'd4;
      r.exception.badvaddr = c.write_reg.value;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_load(op_t op, logic [31:0] a, logic [31:0] d);
    logic [31:0] v;
    int n = nbytes(op);
    if (n == 4) return d;
    if (n == 1) begin
      v = (d >> (8 * (a % 4))) & 32'hff;
      if (op == OP_LB && v >= 128) v = v | 32'hffffff00;
    end else begin
      v = (d >> (16 * ((a % 4) / 2))) & 32'hffff;
      if (op == OP_LH && v >= 32'h8000) v = v | 32'hffff0000;
    end
    return v;
  endfunction

  task automatic serve(inout write_single_context_t e, input int d_addr, input int d_data,
                       input logic [31:0] rd, input string tag);
    int n = nbytes(e.op);
    logic [31:0] a = e.write_reg.value;
    logic [3:0] strb = is_st(e.op) ? 4'(((1 << n) - 1) << (a % 4)) : 4'h0;
    logic [31:0] wd = (n == 1) ? (e.store_data & 32'hff) * 32'h01010101 :
                      (n == 2) ? (e.store_data & 32'hffff) * 32'h00010001 : e.store_data;
    logic [1:0] sz = (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2;
    for (int k = 0; k <= d_addr; k++) begin
      chk({tag, ".dreq_valid"}, dreq_valid, 1);
      chk({tag, ".req"}, {dreq_addr, dreq_size, dreq_strobe}, {a, sz, strb});
      if (is_st(e.op)) chk({tag, ".wdata"}, dreq_data, wd);
      chk({tag, ".busy"}, in_ready, 0);
      if (k == d_addr) begin
        addr_ok = 1;
        if (d_data == 0) begin data_ok = 1; rdata = rd; end
      end
      @(posedge clk); #1;
      addr_ok = 0; data_ok = 0;
    end
    if (d_data > 0) begin
      for (int k = 1; k < d_data; k++) begin
        chk({tag, ".wait_noreq"}, dreq_valid, 0);
        chk({tag, ".wait_busy"}, in_ready, 0);
        @(posedge clk); #1;
      end
      data_ok = 1; rdata = rd;
      @(posedge clk); #1;
      data_ok = 0;
    end
    if (nbytes(e.op) > 0 && !is_st(e.op)) e.write_reg.value = ref_load(e.op, a, rd);
  endtask

  task automatic run_bundle(input write_single_context_t a, input write_single_context_t b,
                            input int d_addr, input int d_data, input logic [31:0] rd1,
                            input logic [31:0] rd2, input string tag,
                            output write_single_context_t q1, output write_single_context_t q2);
    write_single_context_t e1, e2;
    bit kill, go1, go2;
    e1 = ref_check(a);
    kill = e1.exception.valid || a.op == OP_ERET || a.op == OP_MTC0;
    e2 = kill ? b : ref_check(b);
    go1 = nbytes(e1.op) > 0 && !e1.exception.valid;
    go2 = !kill && nbytes(e2.op) > 0 && !e2.exception.valid;
    chk({tag, ".ready_in"}, in_ready, 1);
    c1 = a; c2 = b; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    if (go1) serve(e1, d_addr, d_data, rd1, {tag, ".l1"});
    if (go2) serve(e2, d_addr, d_data, rd2, {tag, ".l2"});
    chk({tag, ".emit1"}, m1, e1);
    chk({tag, ".emit2"}, m2, e2);
    chk({tag, ".ready_emit"}, in_ready, 1);
    chk({tag, ".noreq_emit"}, dreq_valid, 0);
    q1 = m1; q2 = m2;
    @(posedge clk); #1;
    chk({tag, ".nop1"}, m1, CTX_NOP);
    chk({tag, ".nop2"}, m2, CTX_NOP);
  endtask

  function automatic write_single_context_t mk(op_t op, logic [31:0] addr, logic [31:0] sd);
    write_single_context_t c = '0;
    c.op = op; c.pc = 32'hbfc0_0000 + addr[11:0];
    c.write_reg.valid = !is_st(op); c.write_reg.id = 5'd3; c.write_reg.value = addr;
    c.store_data = sd;
    return c;
  endfunction

  function automatic write_single_context_t rand_ctx();
    op_t ops[12] = '{OP_NOP, OP_ADD, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
                     OP_SB, OP_SH, OP_SW, OP_ERET, OP_MTC0};
    write_single_context_t c;
    c = mk(ops[$urandom_range(0, 11)], $urandom, $urandom);
    c.write_reg.id = 5'($urandom);
    if ($urandom_range(0, 1) == 1) c.write_reg.value[1:0] = 2'b00;
    if ($urandom_range(0, 7) == 0) begin
      c.exception.valid = 1; c.exception.exccode = 5'($urandom); c.exception.badvaddr = $urandom;
    end
    return c;
  endfunction

  initial begin
    #1;
    chk("rst.ready", in_ready, 1);
    chk("rst.dreq", dreq_valid, 0);
    chk("rst.m1", m1, CTX_NOP);
    chk("rst.m2", m2, CTX_NOP);
    @(posedge clk); #1;
    resetn = 1;
    @(posedge clk); #1;

    run_bundle(mk(OP_LW, 32'h80001004, 0), mk(OP_ADD, 32'h11, 0), 0, 1, 32'hdeadbeef, 0, "lw", o1, o2);
    chk("lw.value", o1.write_reg.value, 32'hdeadbeef);
    chk("lw.lane2", o2, mk(OP_ADD, 32'h11, 0));

    run_bundle(mk(OP_SB, 32'h80000003, 32'h12), mk(OP_LHU, 32'h80000002, 0), 0, 0, 0,
               32'habcd0000, "sb_lhu", o1, o2);
    chk("sb_lhu.value", o2.write_reg.value, 32'h0000abcd);

    run_bundle(mk(OP_LH, 32'h80000001, 0), mk(OP_LW, 32'h80000100, 0), 0, 0, 0, 0, "adel", o1, o2);
    chk("adel.exc", {o1.exception.valid, o1.exception.exccode, o1.exception.badvaddr},
        {1'b1, 5'd4, 32'h80000001});
    chk("adel.lane2", o2, mk(OP_LW, 32'h80000100, 0));

    run_bundle(mk(OP_LB, 32'h80000001, 0), mk(OP_NOP, 0, 0), 1, 0, 32'h00008000, 0, "lb", o1, o2);
    chk("lb.value", o1.write_reg.value, 32'hffffff80);
    run_bundle(mk(OP_LBU, 32'h80000001, 0), mk(OP_NOP, 0, 0), 0, 2, 32'h00008000, 0, "lbu", o1, o2);
    chk("lbu.value", o1.write_reg.value, 32'h00000080);

    run_bundle(mk(OP_SH, 32'h80000006, 32'h5a5a1234), mk(OP_SW, 32'h80000008, 32'hcafef00d),
               5, 1, 0, 0, "stall", o1, o2);
    run_bundle(mk(OP_SW, 32'h80000002, 1), mk(OP_LW, 32'h80000004, 0), 0, 0, 0, 0, "ades", o1, o2);
    chk("ades.code", o1.exception.exccode, 5'd5);
    run_bundle(mk(OP_ERET, 0, 0), mk(OP_LW, 32'h80000004, 0), 0, 0, 0, 0, "eret", o1, o2);

    c1 = mk(OP_LW, 32'h80000010, 0); c2 = mk(OP_LW, 32'h80000020, 0); in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; addr_ok = 1;
    @(posedge clk); #1;
    addr_ok = 0;
    chk("fw.wait_noreq", dreq_valid, 0);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    for (int k = 0; k < 2; k++) begin
      chk("fw.drain_busy", in_ready, 0);
      chk("fw.drain_noreq", dreq_valid, 0);
      chk("fw.drain_nop", m1, CTX_NOP);
      @(posedge clk); #1;
    end
    data_ok = 1; rdata = 32'h12345678;
    @(posedge clk); #1;
    data_ok = 0;
    chk("fw.ready", in_ready, 1);
    chk("fw.nop1", m1, CTX_NOP);
    chk("fw.nop2", m2, CTX_NOP);
    @(posedge clk); #1;
    chk("fw.no_req2", dreq_valid, 0);

    c1 = mk(OP_SW, 32'h80000030, 7); c2 = mk(OP_NOP, 0, 0); in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    chk("fr.req", dreq_valid, 1);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("fr.noreq", dreq_valid, 0);
    chk("fr.ready", in_ready, 1);
    chk("fr.nop", m1, CTX_NOP);

    c1 = mk(OP_LW, 32'h80000040, 0); in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    resetn = 0;
    #1;
    chk("ar.noreq", dreq_valid, 0);
    chk("ar.ready", in_ready, 1);
    @(posedge clk); #1;
    resetn = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      t1 = rand_ctx(); t2 = rand_ctx();
      run_bundle(t1, t2, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom,
                 $sformatf("rnd%0d", i), o1, o2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/memory_double_stage.md
Name: memory_double_stage

Overview:
- Dual-issue memory stage, directly upstream of the dual write-back stage.
- Accepts a two-lane bundle from execute and serialises lane-1 then lane-2 load/store accesses over a single data-cache request/response port.
- Performs alignment checks, store strobe generation and load extraction with sign/zero extension.
- Registers the finished bundle onto memory2write_1/memory2write_2; write-back is always ready.

Parameters:
- (none; all widths fixed by common.svh / mycpu.svh types)

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- in_valid  in  1  execute bundle valid
- in_ready  out  1  stage accepts a new bundle this cycle
- execute2memory_1  in  write_single_context_t  lane-1 context (op, pc, address in write_reg.value for mem ops, store data, exception)
- execute2memory_2  in  write_single_context_t  lane-2 context
- flush  in  1  write-back exception_valid OR ERET_exist
- dreq_valid  out  1  data request valid
- dreq_addr  out  32  byte address
- dreq_size  out  2  0=byte,1=half,2=word
- dreq_strobe  out  4  byte write enables (0 = read)
- dreq_data  out  32  store data, lane-shifted
- dresp_addr_ok  in  1  request accepted
- dresp_data_ok  in  1  response/data valid
- dresp_rdata  in  32  load word
- memory2write_1  out  write_single_context_t  registered lane-1 result
- memory2write_2  out  write_single_context_t  registered lane-2 result

Behaviour:
- Reset (async, resetn=0): state=IDLE, memory2write_1/2 = NOP context (op=NOP, write_reg.valid=0, exception.valid=0), dreq_valid=0, in_ready=1.
- FSM states: IDLE, REQ1, WAIT1, REQ2, WAIT2, DRAIN.
- IDLE:
  - in_ready=1. On in_valid, latch both lanes and run the alignment check.
  - AdEL applies to LW with addr[1:0]!=0 and LH/LHU with addr[0]!=0. AdES applies to SW/SH under the same rules. Each sets exception.valid and BadVAddr=addr.
  - Lane 2 is "killed" if lane 1 carries an exception, is ERET, or is MTC0. A killed lane 2 issues no access and is emitted unchanged.
  - Next state: REQ1 if lane 1 is a valid mem op without exception; else REQ2 if lane 2 is a live mem op; else emit the bundle next cycle and stay IDLE (latency 1).
- REQx: dreq_valid=1, fields held stable until dresp_addr_ok. On addr_ok go to WAITx. If addr_ok and data_ok arrive in the same cycle, treat as complete.
- WAITx: on data_ok, capture the load result. Then from WAIT1 go to REQ2 if lane 2 is a live mem op, else emit. From WAIT2, emit.
- Emit: memory2write_1/2 are updated with the completed lanes for exactly one cycle. In every other cycle they are NOP. The stage returns to IDLE with in_ready=1 in that same cycle.
- in_ready=0 in all states except IDLE and the emit cycle.
- Load extraction, with b = addr[1:0]:
  - LB/LBU: byte b, sign- or zero-extended to 32.
  - LH/LHU: half addr[1], sign- or zero-extended.
  - LW: whole word.
  - Result goes to write_reg.value.
- Stores:
  - SB: strobe = 1<<b, data replicated ×4.
  - SH: strobe = 4'b0011 or 4'b1100, data replicated ×2.
  - SW: strobe = 4'b1111.
  - Loads drive strobe=0.
- Flush (synchronous, clk edge):
  - IDLE or REQx: drop the bundle, dreq_valid deasserts next cycle, go to IDLE, output NOP.
  - WAITx: go to DRAIN. DRAIN waits for data_ok, discards it, then goes to IDLE. in_ready=0 throughout.
  - Flush has priority over in_valid and over emit.
- Exactly one outstanding dcache transaction at any time. No request is issued while in DRAIN.
- resetn low mid-transaction: immediate return to IDLE. The dcache is reset by the same signal.

Test Plan:
- Lane1 LW addr 0x80001004, lane2 ADD: addr_ok cycle 1, data_ok cycle 2 with rdata 0xDEADBEEF -> memory2write_1.write_reg.value=0xDEADBEEF, lane 2 unchanged, 1-cycle emit, then NOP.
- Lane1 SB addr 0x...03 data 0x12, lane2 LHU addr 0x...02 with rdata 0xABCD0000 -> first request strobe=4'b1000 data=0x12121212, second request strobe=0; lane-2 value=0x0000ABCD.
- Lane1 LH addr 0x...01 -> lane-1 AdEL with BadVAddr=0x...01, no dreq_valid, lane-2 LW is not issued, emit after 1 cycle.
- LB with rdata 0x00008000, addr[1:0]=1 -> value 0xFFFFFF80; LBU with the same inputs -> 0x00000080.
- Flush asserted in WAIT1 (data_ok 3 cycles later) -> DRAIN, no REQ2, output NOP, in_ready returns to 1 the cycle after data_ok.
- dresp_addr_ok held low 5 cycles in REQ1 -> dreq_addr/size/strobe/data stable throughout, in_ready=0.
